// File: rtl/window_gen_if.sv
// Purpose: groups the frame-control, pixel-stream and window-output signals of
//          window_gen into one bundle.
// Signals:
//   run_i, img_w_i, img_h_i   frame start pulse and run-time image size
//   data_i, data_en_i         raster pixel stream
//   win_o, win_en_o           flattened KSIZE x KSIZE window and its strobe
//   win_row_o, win_col_o      centre coordinates of the current window
//   busy_o, done_o            frame status
// Modports: master drives the stream and control (source side), slave is the
//           window generator.
interface window_gen_if #(
  parameter int KSIZE   = 3,
  parameter int DATA_W  = 8,
  parameter int MAX_COL = 540,
  parameter int MAX_ROW = 540
);
  logic                            run_i;
  logic [$clog2(MAX_COL+1)-1:0]    img_w_i;
  logic [$clog2(MAX_ROW+1)-1:0]    img_h_i;
  logic [DATA_W-1:0]               data_i;
  logic                            data_en_i;
  logic [KSIZE*KSIZE*DATA_W-1:0]   win_o;
  logic                            win_en_o;
  logic [$clog2(MAX_ROW)-1:0]      win_row_o;
  logic [$clog2(MAX_COL)-1:0]      win_col_o;
  logic                            busy_o;
  logic                            done_o;

  modport master (
    output run_i, img_w_i, img_h_i, data_i, data_en_i,
    input  win_o, win_en_o, win_row_o, win_col_o, busy_o, done_o
  );

  modport slave (
    input  run_i, img_w_i, img_h_i, data_i, data_en_i,
    output win_o, win_en_o, win_row_o, win_col_o, busy_o, done_o
  );
endinterface

// File: rtl/window_gen.sv
// Purpose: turns a raster pixel stream into KSIZE x KSIZE sliding windows
//          (valid-only border) using KSIZE-1 line buffers and a window shift
//          register. Image size is latched when a frame starts.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   window_gen_if.slave: run/size in, pixel stream in, window out,
//         busy/done status out
//
// state  | meaning
// IDLE   | waiting for run_i; done_o may be high here for one cycle
// FILL   | consuming pixels, no window produced yet
// RUN    | consuming pixels, windows being produced
// DONE   | last pixel accepted; final win_en_o may be high; done_o next
module window_gen #(
  parameter int KSIZE   = 3,
  parameter int DATA_W  = 8,
  parameter int MAX_COL = 540,
  parameter int MAX_ROW = 540
) (
  input  logic         clk,
  input  logic         rst,
  window_gen_if.slave  bus
);
  localparam int WW    = $clog2(MAX_COL+1);
  localparam int HW    = $clog2(MAX_ROW+1);
  localparam int CW    = $clog2(MAX_COL);
  localparam int RW    = $clog2(MAX_ROW);
  localparam int HALF  = (KSIZE-1)/2;
  localparam int WIN_W = KSIZE*KSIZE*DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       img_w_q, img_w_d, col_q, col_d;
  logic [HW-1:0]       img_h_q, img_h_d, row_q, row_d;
  logic [DATA_W-1:0]   sh_q [KSIZE][KSIZE];
  logic [DATA_W-1:0]   sh_d [KSIZE][KSIZE];
  logic [WIN_W-1:0]    win_q, win_d;
  logic                win_en_q, win_en_d;
  logic [RW-1:0]       win_row_q, win_row_d;
  logic [CW-1:0]       win_col_q, win_col_d;
  logic                done_q, done_d;

  // line_buf[0] holds the previous image row, line_buf[k] the row k+1 above.
  logic [DATA_W-1:0]   line_buf [KSIZE-1][MAX_COL];

  logic                accept, last_col, last_row, win_valid;
  logic [CW-1:0]       col_idx;

  always_comb begin
    col_idx   = CW'(col_q);
    accept    = ((state_q == S_FILL) || (state_q == S_RUN)) && bus.data_en_i;
    last_col  = (col_q == img_w_q - WW'(1));
    last_row  = (row_q == img_h_q - HW'(1));
    // A window is complete only when KSIZE columns of the current row exist,
    // so it never straddles a row wrap.
    win_valid = accept && (col_q >= WW'(KSIZE-1)) && (row_q >= HW'(KSIZE-1));
  end

  always_comb begin
    state_d   = state_q;
    img_w_d   = img_w_q;
    img_h_d   = img_h_q;
    col_d     = col_q;
    row_d     = row_q;
    sh_d      = sh_q;
    win_d     = win_q;
    win_en_d  = win_valid;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run_i) begin
          img_w_d = bus.img_w_i;
          img_h_d = bus.img_h_i;
          col_d   = '0;
          row_d   = '0;
          if ((bus.img_w_i == '0) || (bus.img_h_i == '0)) state_d = S_DONE;
          else                                            state_d = S_FILL;
        end
      end
      S_FILL, S_RUN: begin
        if (accept) begin
          if (win_valid) state_d = S_RUN;
          if (last_col && last_row) state_d = S_DONE;
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + HW'(1);
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE-1; c++) sh_d[r][c] = sh_q[r][c+1];
      end
      // New right-hand column: oldest buffered row at the top, live pixel at the bottom.
      for (int r = 0; r < KSIZE-1; r++) sh_d[r][KSIZE-1] = line_buf[KSIZE-2-r][col_idx];
      sh_d[KSIZE-1][KSIZE-1] = bus.data_i;
    end

    // Window output is captured separately so it holds between strobes while
    // the shift register keeps moving.
    if (win_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) win_d[(r*KSIZE+c)*DATA_W +: DATA_W] = sh_d[r][c];
      end
      win_row_d = RW'(row_q - HW'(HALF));
      win_col_d = CW'(col_q - WW'(HALF));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      img_w_q   <= '0;
      img_h_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      win_en_q  <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      done_q    <= 1'b0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) sh_q[r][c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      img_w_q   <= img_w_d;
      img_h_q   <= img_h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sh_q      <= sh_d;
      win_q     <= win_d;
      win_en_q  <= win_en_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      done_q    <= done_d;
    end
  end

  // Line buffers carry no reset; their contents are overwritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col_idx] <= bus.data_i;
      for (int k = 1; k < KSIZE-1; k++) line_buf[k][col_idx] <= line_buf[k-1][col_idx];
    end
  end

  assign bus.win_o     = win_q;
  assign bus.win_en_o  = win_en_q;
  assign bus.win_row_o = win_row_q;
  assign bus.win_col_o = win_col_q;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [9:0] img_w, img_h;
  logic [7:0] data;
  logic       den;

  always #5 clk = ~clk;

  window_gen_if #(.KSIZE(3)) bus3 ();
  window_gen_if #(.KSIZE(5)) bus5 ();

  assign bus3.run_i = run;  assign bus3.img_w_i = img_w;  assign bus3.img_h_i = img_h;
  assign bus3.data_i = data; assign bus3.data_en_i = den;
  assign bus5.run_i = run;  assign bus5.img_w_i = img_w;  assign bus5.img_h_i = img_h;
  assign bus5.data_i = data; assign bus5.data_en_i = den;

  window_gen #(.KSIZE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  window_gen #(.KSIZE(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampling on the falling edge.
  logic [71:0]  q3_win [$];
  int           q3_row [$];
  int           q3_col [$];
  logic [199:0] q5_first;
  int           n5, last5_row, last5_col;
  int           done3, done5, done3_cyc, done5_cyc, last3_cyc, overlap;
  int           last_pix_cyc;

  always @(negedge clk) begin
    if (bus3.win_en_o) begin
      q3_win.push_back(bus3.win_o);
      q3_row.push_back(int'(bus3.win_row_o));
      q3_col.push_back(int'(bus3.win_col_o));
      last3_cyc = cyc;
      if (bus3.done_o) overlap++;
    end
    if (bus3.done_o) begin done3++; done3_cyc = cyc; end
    if (bus5.win_en_o) begin
      if (n5 == 0) q5_first = bus5.win_o;
      n5++;
      last5_row = int'(bus5.win_row_o);
      last5_col = int'(bus5.win_col_o);
      if (bus5.done_o) overlap++;
    end
    if (bus5.done_o) begin done5++; done5_cyc = cyc; end
  end

  task automatic clear_mon();
    q3_win.delete(); q3_row.delete(); q3_col.delete();
    n5 = 0; done3 = 0; done5 = 0; overlap = 0;
    done3_cyc = -1; done5_cyc = -1; last3_cyc = -1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_win3(input int w_, input int i);
    int nw, er, ec;
    logic [71:0] e;
    nw = w_ - 2; er = i / nw + 1; ec = i % nw + 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) e[(r*3+c)*8 +: 8] = 8'((er-1+r)*16 + (ec-1+c));
    return e;
  endfunction

  task automatic check_frame3(input int w_, input int h_, input int base);
    int nw, nwin;
    nw = w_ - 2; nwin = nw * (h_ - 2);
    for (int i = 0; i < nwin; i++) begin
      if (base + i >= q3_win.size()) begin
        n_checks++; n_fail++;
        $display("FAIL win3_missing: window %0d absent, only %0d captured", base+i, q3_win.size());
      end else begin
        chk($sformatf("win3_row[%0d]", base+i), 256'(q3_row[base+i]), 256'(i / nw + 1));
        chk($sformatf("win3_col[%0d]", base+i), 256'(q3_col[base+i]), 256'(i % nw + 1));
        chk($sformatf("win3_data[%0d]", base+i), 256'(q3_win[base+i]), 256'(exp_win3(w_, i)));
      end
    end
  endtask

  task automatic start(input int w_, input int h_);
    run = 1'b1; img_w = 10'(w_); img_h = 10'(h_);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic drive_pixels(input int w_, input int h_, input int gap, input int poke,
                              input int limit);
    int n;
    n = 0;
    for (int r = 0; r < h_; r++) begin
      for (int c = 0; c < w_; c++) begin
        if (n < limit) begin
          if (gap != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
          if (poke != 0 && r == 1 && c == 0) begin
            run = 1'b1; img_w = 10'd7; img_h = 10'd7;
            @(negedge clk);
            run = 1'b0;
          end
          data = 8'(r*16 + c); den = 1'b1; last_pix_cyc = cyc;
          @(negedge clk);
          den = 1'b0;
          n++;
        end
      end
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done3 < target && t < 3000) begin @(negedge clk); t++; end
    if (done3 < target) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: done3=%0d required %0d", done3, target);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy3"},   256'(bus3.busy_o),   256'(0));
    chk({tag, "_done3"},   256'(bus3.done_o),   256'(0));
    chk({tag, "_winen3"},  256'(bus3.win_en_o), 256'(0));
    chk({tag, "_win3"},    256'(bus3.win_o),    256'(0));
    chk({tag, "_row3"},    256'(bus3.win_row_o), 256'(0));
    chk({tag, "_col3"},    256'(bus3.win_col_o), 256'(0));
    chk({tag, "_busy5"},   256'(bus5.busy_o),   256'(0));
    chk({tag, "_win5"},    256'(bus5.win_o),    256'(0));
  endtask

  typedef struct {
    int w; int h; int gap; int poke;
    int exp3; int exp5; int last_r; int last_c;
  } vec_t;

  vec_t vecs [5];
  logic [199:0] e5;
  int t0, zc;

  initial begin
    vecs[0] = '{w:5, h:4, gap:0, poke:0, exp3:6,  exp5:0,  last_r:2, last_c:3};
    vecs[1] = '{w:5, h:4, gap:1, poke:0, exp3:6,  exp5:0,  last_r:2, last_c:3};
    vecs[2] = '{w:8, h:8, gap:0, poke:0, exp3:36, exp5:16, last_r:6, last_c:6};
    vecs[3] = '{w:2, h:4, gap:0, poke:1, exp3:0,  exp5:0,  last_r:0, last_c:0};
    vecs[4] = '{w:6, h:3, gap:1, poke:0, exp3:4,  exp5:0,  last_r:1, last_c:4};

    rst = 1'b1; run = 1'b0; img_w = '0; img_h = '0; data = '0; den = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      clear_mon();
      start(vecs[v].w, vecs[v].h);
      chk($sformatf("v%0d_busy", v), 256'(bus3.busy_o), 256'(1));
      drive_pixels(vecs[v].w, vecs[v].h, vecs[v].gap, vecs[v].poke, 1 << 20);
      wait_done(1);
      chk($sformatf("v%0d_count3", v), 256'(q3_win.size()), 256'(vecs[v].exp3));
      chk($sformatf("v%0d_count5", v), 256'(n5), 256'(vecs[v].exp5));
      chk($sformatf("v%0d_done3_n", v), 256'(done3), 256'(1));
      chk($sformatf("v%0d_done5_n", v), 256'(done5), 256'(1));
      chk($sformatf("v%0d_done3_cyc", v), 256'(done3_cyc), 256'(last_pix_cyc + 2));
      chk($sformatf("v%0d_done5_cyc", v), 256'(done5_cyc), 256'(last_pix_cyc + 2));
      chk($sformatf("v%0d_overlap", v), 256'(overlap), 256'(0));
      chk($sformatf("v%0d_busy_end", v), 256'(bus3.busy_o), 256'(0));
      if (vecs[v].exp3 > 0) begin
        check_frame3(vecs[v].w, vecs[v].h, 0);
        chk($sformatf("v%0d_last_win_cyc", v), 256'(last3_cyc), 256'(last_pix_cyc + 1));
        chk($sformatf("v%0d_last_row", v), 256'(q3_row[q3_row.size()-1]), 256'(vecs[v].last_r));
        chk($sformatf("v%0d_last_col", v), 256'(q3_col[q3_col.size()-1]), 256'(vecs[v].last_c));
        chk($sformatf("v%0d_hold", v), 256'(bus3.win_o),
            256'(exp_win3(vecs[v].w, vecs[v].exp3 - 1)));
      end
      if (vecs[v].exp5 > 0) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) e5[(r*5+c)*8 +: 8] = 8'(r*16 + c);
        chk($sformatf("v%0d_k5_first", v), 256'(q5_first), 256'(e5));
        chk($sformatf("v%0d_k5_e44", v), 256'(q5_first[24*8 +: 8]), 256'(8'h44));
        chk($sformatf("v%0d_k5_last_row", v), 256'(last5_row), 256'(vecs[v].h - 3));
        chk($sformatf("v%0d_k5_last_col", v), 256'(last5_col), 256'(vecs[v].w - 3));
      end
    end

    // Zero-width frame: straight to DONE, no pixels consumed.
    clear_mon();
    t0 = cyc;
    start(0, 3);
    repeat (4) @(negedge clk);
    chk("zero_done_n", 256'(done3), 256'(1));
    chk("zero_done_cyc", 256'(done3_cyc), 256'(t0 + 2));
    chk("zero_wins", 256'(q3_win.size()), 256'(0));

    // Reset in the middle of a frame, then a clean frame.
    clear_mon();
    start(5, 4);
    drive_pixels(5, 4, 0, 0, 7);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 256'(done3 + done5), 256'(0));
    clear_mon();
    start(5, 4);
    drive_pixels(5, 4, 0, 0, 1 << 20);
    wait_done(1);
    chk("after_rst_count", 256'(q3_win.size()), 256'(6));
    check_frame3(5, 4, 0);
    chk("after_rst_done_cyc", 256'(done3_cyc), 256'(last_pix_cyc + 2));

    // Back-to-back frames, second run_i on the done_o cycle.
    clear_mon();
    start(5, 4);
    drive_pixels(5, 4, 0, 0, 1 << 20);
    zc = 0;
    while (!bus3.done_o && zc < 50) begin @(negedge clk); zc++; end
    chk("b2b_done_seen", 256'(bus3.done_o), 256'(1));
    start(6, 3);
    chk("b2b_busy", 256'(bus3.busy_o), 256'(1));
    drive_pixels(6, 3, 0, 0, 1 << 20);
    wait_done(2);
    chk("b2b_count", 256'(q3_win.size()), 256'(10));
    chk("b2b_done_n", 256'(done3), 256'(2));
    chk("b2b_overlap", 256'(overlap), 256'(0));
    check_frame3(5, 4, 0);
    check_frame3(6, 3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
